// File: rtl/jpeg_out_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_out_pkg
// Shared definitions for the JPEG output scheduler: FSM state encoding, MCU
// geometry for both picture types, and the frame-buffer pixel size.
// Ports: none (package).
// -----------------------------------------------------------------------------
package jpeg_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MCU_PIX_411 = 256;
    localparam int MCU_PIX_444 = 64;
    localparam int MCU_DIM_411 = 16;
    localparam int MCU_DIM_444 = 8;
    localparam int PIX_BYTES   = 4;

    // Index of the last pixel inside one MCU for the given picture type.
    function automatic logic [7:0] lastIdx(input logic isType411);
        return isType411 ? 8'(MCU_PIX_411 - 1) : 8'(MCU_PIX_444 - 1);
    endfunction

endpackage

// File: rtl/jpeg_out_fifo.sv
// -----------------------------------------------------------------------------
// jpeg_out_fifo
// Small synchronous FIFO holding {address, data} write entries between the
// address stage and the frame-buffer write port. DEPTH must be a power of two
// so the pointers wrap naturally.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push        write i_data (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   i_data        entry to store
//   o_data        head entry
//   o_empty       no entries held
//   o_count       number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module jpeg_out_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && (r_count != CNT_W'(DEPTH));
    assign w_doPop  = i_pop  && (r_count != '0);

    // Storage is cleared on reset so the head output reads zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/jpeg_out_sched.sv
// -----------------------------------------------------------------------------
// jpeg_out_sched
// Output scheduler between the JPEG decoder pixel stream and a frame-buffer
// write port. Paces the decoder read strobe from buffer occupancy, tracks the
// MCU / in-MCU position of every pixel, turns it into a raster byte address,
// and issues one 32-bit write per pixel over a req/gnt handshake.
// Optional feature macro: JPEG_OUT_ALPHA_EN (forces the alpha byte of every
// written pixel, adds the cfg_alpha input).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_we/s_begin/s_end       decoder pixel valid, first and last pixel flags
//   s_data, s_type           pixel {r,g,b,x}, picture type (1 = 4:1:1)
//   s_next                   read strobe: a pixel may be transferred
//   cfg_base/stride/mcu_w    frame geometry, sampled on the begin pixel
//   cfg_alpha                alpha override (only with JPEG_OUT_ALPHA_EN)
//   m_req/m_gnt              write request / accepted
//   m_addr, m_data           head write entry
//   frame_done               one-cycle pulse when the frame has fully drained
//   err                      sticky protocol error
// -----------------------------------------------------------------------------
module jpeg_out_sched
    import jpeg_out_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_we,
    input  logic              s_begin,
    input  logic              s_end,
    input  logic [31:0]       s_data,
    input  logic              s_type,
    output logic              s_next,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [15:0]       cfg_stride,
    input  logic [12:0]       cfg_mcu_w,
`ifdef JPEG_OUT_ALPHA_EN
    input  logic [7:0]        cfg_alpha,
`endif
    output logic              m_req,
    input  logic              m_gnt,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_data,
    output logic              frame_done,
    output logic              err
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + 32;

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_stride;
    logic [12:0]       r_mcuW;
    logic              r_type;
    logic [7:0]        r_idx;
    logic [12:0]       r_mx;
    logic [15:0]       r_my;
    logic              r_err;
    logic              r_stgValid;
    logic [ADDR_W-1:0] r_stgAddr;
    logic [31:0]       r_stgData;

    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic               w_ready;
    logic               w_accept;
    logic               w_take;
    logic               w_restart;
    logic               w_done;
    logic [31:0]        w_mb;
    logic [31:0]        w_px;
    logic [31:0]        w_py;
    logic [31:0]        w_line;
    logic [31:0]        w_col;
    logic [31:0]        w_pixOff;
    logic [31:0]        w_byteOff;
    logic [ADDR_W-1:0]  w_addrCalc;
    logic [31:0]        w_pixData;

    // Two free entries are required: one for the pixel being accepted and one
    // for the pixel already sitting in the address stage.
    assign w_ready   = ((r_state == IDLE) || (r_state == RUN)) &&
                       ((CNT_W'(FIFO_DEPTH) - w_count) >= CNT_W'(2));
    assign s_next    = w_ready && !rst;
    assign w_accept  = s_we && s_next;
    // In IDLE only a begin pixel is kept; any other accepted pixel is dropped.
    assign w_take    = w_accept && (s_begin || (r_state == RUN));
    assign w_restart = w_take && s_begin;

`ifdef JPEG_OUT_ALPHA_EN
    logic [7:0] r_alpha;
    logic [7:0] w_alphaSel;

    // The begin pixel already uses the freshly presented alpha value.
    always_comb begin
        w_alphaSel = s_begin ? cfg_alpha : r_alpha;
        w_pixData  = {s_data[31:8], (w_alphaSel != 8'h00) ? w_alphaSel : 8'hFF};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alpha <= 8'h00;
        end else if (w_restart) begin
            r_alpha <= cfg_alpha;
        end
    end
`else
    assign w_pixData = s_data;
`endif

    // Raster byte address of the pixel the counters currently point at. All
    // arithmetic is done at 32 bits and truncated to the address width.
    always_comb begin
        w_mb       = r_type ? 32'(MCU_DIM_411) : 32'(MCU_DIM_444);
        w_px       = r_type ? 32'(r_idx[3:0]) : 32'(r_idx[2:0]);
        w_py       = r_type ? 32'(r_idx[7:4]) : 32'(r_idx[5:3]);
        w_line     = 32'(r_my) * w_mb + w_py;
        w_col      = 32'(r_mx) * w_mb + w_px;
        w_pixOff   = w_line * 32'(r_stride) + w_col;
        w_byteOff  = w_pixOff * 32'(PIX_BYTES);
        w_addrCalc = r_base + ADDR_W'(w_byteOff);
    end

    // Position counters and latched frame config. A begin pixel is pixel 0 of
    // a fresh frame, so after it the counters already point at pixel 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_stride <= '0;
            r_mcuW   <= '0;
            r_type   <= 1'b0;
            r_idx    <= '0;
            r_mx     <= '0;
            r_my     <= '0;
        end else if (w_restart) begin
            r_base   <= cfg_base;
            r_stride <= cfg_stride;
            r_mcuW   <= cfg_mcu_w;
            r_type   <= s_type;
            r_idx    <= 8'd1;
            r_mx     <= '0;
            r_my     <= '0;
        end else if (w_take) begin
            if (r_idx == lastIdx(r_type)) begin
                r_idx <= '0;
                if (r_mx == (r_mcuW - 13'd1)) begin
                    r_mx <= '0;
                    r_my <= r_my + 16'd1;
                end else begin
                    r_mx <= r_mx + 13'd1;
                end
            end else begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Address stage: one register between acceptance and the FIFO push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stgValid <= 1'b0;
            r_stgAddr  <= '0;
            r_stgData  <= '0;
        end else begin
            r_stgValid <= w_take;
            if (w_take) begin
                r_stgAddr <= w_restart ? cfg_base : w_addrCalc;
                r_stgData <= w_pixData;
            end
        end
    end

    // Sticky error: dropped pixel in IDLE, begin inside a frame, or a pixel
    // whose type disagrees with the type latched on the begin pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((w_accept && !w_take) ||
                     (w_accept && (r_state == RUN) && s_begin) ||
                     (w_take && !s_begin && (s_type != r_type))) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Frame sequencing; frame_done fires once the stage and FIFO are empty.
    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_restart) begin
                    w_stateNext = s_end ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (w_take && s_end) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (w_empty && !r_stgValid) begin
                    w_done      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    jpeg_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_stgValid),
        .i_pop   (m_gnt),
        .i_data  ({r_stgAddr, r_stgData}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign m_req      = !w_empty;
    assign m_addr     = w_head[ENTRY_W-1:32];
    assign m_data     = w_head[31:0];
    assign frame_done = w_done;
    assign err        = r_err;

endmodule

// File: tb/tb_jpeg_out_sched.sv
// -----------------------------------------------------------------------------
// tb_jpeg_out_sched
// Directed self-checking bench for jpeg_out_sched. Inputs change 2 ns after
// the rising edge; outputs and handshakes are observed on the falling edge.
// Supports the optional JPEG_OUT_ALPHA_EN build (connects cfg_alpha).
// -----------------------------------------------------------------------------
module tb_jpeg_out_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_we = 1'b0;
    logic        s_begin = 1'b0;
    logic        s_end = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_type = 1'b0;
    logic        s_next;
    logic [31:0] cfg_base = '0;
    logic [15:0] cfg_stride = '0;
    logic [12:0] cfg_mcu_w = '0;
    logic [7:0]  cfg_alpha = 8'h00;
    logic        m_req;
    logic        m_gnt = 1'b1;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        frame_done;
    logic        err;

    int nChecks = 0;
    int nBad    = 0;

    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    int          doneCnt  = 0;
    int          wrAtDone = 0;

    jpeg_out_sched #(
        .ADDR_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_we       (s_we),
        .s_begin    (s_begin),
        .s_end      (s_end),
        .s_data     (s_data),
        .s_type     (s_type),
        .s_next     (s_next),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .cfg_mcu_w  (cfg_mcu_w),
`ifdef JPEG_OUT_ALPHA_EN
        .cfg_alpha  (cfg_alpha),
`endif
        .m_req      (m_req),
        .m_gnt      (m_gnt),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write and frame-completion log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_req && m_gnt) begin
                wrAddr.push_back(m_addr);
                wrData.push_back(m_data);
            end
            if (frame_done) begin
                doneCnt++;
                wrAtDone = wrAddr.size();
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pixData(input int j);
        logic [7:0] b;
        b = 8'h11 + 8'(j);
        return {b, 24'h223300};
    endfunction

    function automatic logic [31:0] expData(input int j);
        logic [31:0] d;
        d = pixData(j);
`ifdef JPEG_OUT_ALPHA_EN
        d[7:0] = (cfg_alpha != 8'h00) ? cfg_alpha : 8'hFF;
`endif
        return d;
    endfunction

    // Reference address from a flat in-frame pixel index.
    function automatic logic [31:0] expAddr(input logic t, input int k);
        int unsigned mpix, mb, idx, mcu, mx, my, px, py;
        mpix = t ? 256 : 64;
        mb   = t ? 16 : 8;
        idx  = k % mpix;
        mcu  = k / mpix;
        mx   = mcu % cfg_mcu_w;
        my   = mcu / cfg_mcu_w;
        px   = idx % mb;
        py   = idx / mb;
        return cfg_base + 4 * ((my * mb + py) * cfg_stride + mx * mb + px);
    endfunction

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        doneCnt  = 0;
        wrAtDone = 0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        s_we = 1'b0;
        s_begin = 1'b0;
        s_end = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        clearLog();
    endtask

    // Streams n pixels, honouring s_next. restartAt/flipAt (-1 = off) inject a
    // mid-frame begin or a flipped s_type on that pixel.
    task automatic applyStimulus(input logic t, input int n, input int restartAt,
                                 input int flipAt, input logic withEnd);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4000) begin
            @(posedge clk);
            #2;
            s_we    = 1'b1;
            s_begin = (i == 0) || (i == restartAt);
            s_end   = withEnd && (i == n - 1);
            s_type  = (i == flipAt) ? ~t : t;
            s_data  = pixData(i);
            @(negedge clk);
            if (s_next) i++;
            guard++;
        end
        if (i < n) checkOutput("feedStall", i, n);
        @(posedge clk);
        #2;
        s_we    = 1'b0;
        s_begin = 1'b0;
        s_end   = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int guard = 0;
        while (doneCnt < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (doneCnt < target) checkOutput("doneWait", doneCnt, target);
        repeat (4) @(negedge clk);
    endtask

    task automatic verifyFrame(input string name, input logic t, input int n, input int restartAt);
        int badA = 0;
        int badD = 0;
        for (int j = 0; j < wrAddr.size(); j++) begin
            int k;
            k = (restartAt >= 0 && j >= restartAt) ? j - restartAt : j;
            if (wrAddr[j] !== expAddr(t, k)) badA++;
            if (wrData[j] !== expData(j)) badD++;
        end
        checkOutput({name, ".count"}, wrAddr.size(), n);
        checkOutput({name, ".addrAll"}, badA, 0);
        checkOutput({name, ".dataAll"}, badD, 0);
        checkOutput({name, ".doneOnce"}, doneCnt, 1);
        checkOutput({name, ".doneAfterLast"}, wrAtDone, n);
    endtask

    initial begin
        int stallBad;

        // Reset values
        @(posedge clk);
        #1;
        checkOutput("rst.s_next", s_next, 0);
        checkOutput("rst.m_req", m_req, 0);
        checkOutput("rst.m_addr", m_addr, 0);
        checkOutput("rst.m_data", m_data, 0);
        checkOutput("rst.frame_done", frame_done, 0);
        checkOutput("rst.err", err, 0);
        doReset();
        @(negedge clk);
        checkOutput("idle.s_next", s_next, 1);

        // 4:4:4, two MCUs across, grant always high
        cfg_base = 32'h1000; cfg_stride = 16; cfg_mcu_w = 2;
        applyStimulus(1'b0, 128, -1, -1, 1'b1);
        waitDone(1);
        checkOutput("t444.w9", wrAddr[9], 32'h1044);
        checkOutput("t444.w64", wrAddr[64], 32'h1020);
`ifdef JPEG_OUT_ALPHA_EN
        checkOutput("t444.alpha0", wrData[0], 32'h112233FF);
`else
        checkOutput("t444.data0", wrData[0], 32'h11223300);
`endif
        verifyFrame("t444", 1'b0, 128, -1);
        checkOutput("t444.err", err, 0);

        // 4:1:1 single MCU
        clearLog();
        cfg_base = 32'h0; cfg_stride = 16; cfg_mcu_w = 1;
        applyStimulus(1'b1, 256, -1, -1, 1'b1);
        waitDone(1);
        checkOutput("t411.w255", wrAddr[255], 32'h3FC);
        verifyFrame("t411", 1'b1, 256, -1);
        checkOutput("t411.idle", s_next, 1);

        // Backpressure: grant withheld for 20 cycles mid-stream
        clearLog();
        cfg_base = 32'h2000; cfg_stride = 8; cfg_mcu_w = 1;
        fork
            applyStimulus(1'b0, 64, -1, -1, 1'b1);
            begin
                repeat (10) @(negedge clk);
                @(posedge clk);
                #2;
                m_gnt = 1'b0;
                stallBad = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (m_req && (m_addr !== expAddr(1'b0, wrAddr.size()) ||
                                  m_data !== expData(wrAddr.size()))) stallBad++;
                end
                checkOutput("bp.stable", stallBad, 0);
                checkOutput("bp.s_next", s_next, 0);
                checkOutput("bp.m_req", m_req, 1);
                @(posedge clk);
                #2;
                m_gnt = 1'b1;
            end
        join
        waitDone(1);
        verifyFrame("bp", 1'b0, 64, -1);
        checkOutput("bp.err", err, 0);

        // Non-begin pixel in IDLE is dropped and flagged
        clearLog();
        @(posedge clk);
        #2;
        s_we = 1'b1; s_begin = 1'b0; s_end = 1'b0; s_data = 32'hDEADBE00;
        @(posedge clk);
        #2;
        s_we = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("drop.err", err, 1);
        checkOutput("drop.writes", wrAddr.size(), 0);
        checkOutput("drop.m_req", m_req, 0);

        // Begin in the middle of a frame restarts addressing at base
        clearLog();
        cfg_base = 32'h3000; cfg_stride = 16; cfg_mcu_w = 2;
        applyStimulus(1'b0, 10, 5, -1, 1'b1);
        waitDone(1);
        checkOutput("mid.w5", wrAddr[5], 32'h3000);
        verifyFrame("mid", 1'b0, 10, 5);
        checkOutput("mid.err", err, 1);

        // Type mismatch: flagged, latched type still used for addressing
        doReset();
        checkOutput("rst2.err", err, 0);
        cfg_base = 32'h5000; cfg_stride = 16; cfg_mcu_w = 1;
        applyStimulus(1'b0, 8, -1, 3, 1'b1);
        waitDone(1);
        checkOutput("type.w3", wrAddr[3], 32'h500C);
        verifyFrame("type", 1'b0, 8, -1);
        checkOutput("type.err", err, 1);

        // Asynchronous reset mid-RUN with three entries buffered
        clearLog();
        m_gnt = 1'b0;
        cfg_base = 32'h6000; cfg_stride = 8; cfg_mcu_w = 1;
        applyStimulus(1'b0, 3, -1, -1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("ar.preReq", m_req, 1);
        checkOutput("ar.preNext", s_next, 0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ar.m_req", m_req, 0);
        checkOutput("ar.s_next", s_next, 0);
        checkOutput("ar.m_addr", m_addr, 0);
        checkOutput("ar.m_data", m_data, 0);
        checkOutput("ar.frame_done", frame_done, 0);
        checkOutput("ar.err", err, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        m_gnt = 1'b1;
        clearLog();
        cfg_base = 32'h4000; cfg_stride = 8; cfg_mcu_w = 1;
        applyStimulus(1'b0, 64, -1, -1, 1'b1);
        waitDone(1);
        checkOutput("ar.w0", wrAddr[0], 32'h4000);
        verifyFrame("ar", 1'b0, 64, -1);
        checkOutput("ar.errAfter", err, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
